dtc_vote_window: RTL

//  Downstream stage of the dtc decision-tree classifiers. It consumes the per-sample 3-bit class

---
 rtl/dtc_vote_window.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dtc_vote_window.sv
// Majority-vote window over the 3-bit class stream from the dtc classifiers.
// It counts a per-class histogram, scans it for the winner, then holds the result until it is accepted.
module dtc_vote_window #(
  parameter int CLASS_W = 3,
  parameter int WINDOW  = 16,
  parameter int CNT_W   = $clog2(WINDOW + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CLASS_W-1:0] in_class,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CLASS_W-1:0] out_class,
  output logic [CNT_W-1:0]   out_count,
  output logic [CNT_W-1:0]   out_total,
  output logic [1:0]         dbg_state
);

  localparam int NBINS = 2 ** CLASS_W;
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_WIN  = CNT_W'(WINDOW);
  localparam logic [CLASS_W-1:0] IDX_LAST = {CLASS_W{1'b1}};

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCAN  = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

  // Handshakes: a prediction moves on in_valid & in_ready, a result moves on
  // out_valid & out_ready; neither valid ever waits on its ready.
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bin_q [NBINS];
  logic [CNT_W-1:0]   bin_d [NBINS];
  logic [CNT_W-1:0]   total_q, total_d;
  logic [CLASS_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]   best_cnt_q, best_cnt_d;
  logic [CLASS_W-1:0] best_cls_q, best_cls_d;
  logic [CLASS_W-1:0] out_class_q, out_class_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic [CNT_W-1:0]   out_total_q, out_total_d;

  logic in_xfer;
  logic out_xfer;
  logic close_win;

  // in_ready is forced low during reset because the reset state is ACCUM.
  assign in_ready  = (state_q == ST_ACCUM) && !rst;
  assign out_valid = (state_q == ST_EMIT);
  assign out_class = out_class_q;
  assign out_count = out_count_q;
  assign out_total = out_total_q;
  assign dbg_state = state_q;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    total_d     = total_q;
    idx_d       = idx_q;
    best_cnt_d  = best_cnt_q;
    best_cls_d  = best_cls_q;
    out_class_d = out_class_q;
    out_count_d = out_count_q;
    out_total_d = out_total_q;
    close_win   = 1'b0;

    case (state_q)
      ST_ACCUM: begin
        if (in_xfer) begin
          bin_d[in_class] = bin_q[in_class] + CNT_ONE;
          total_d         = total_q + CNT_ONE;
        end
        // A transfer in the flush cycle is already in bin_d/total_d here.
        if (in_xfer && (total_d == CNT_WIN)) close_win = 1'b1;
        if (flush && ((total_q != '0) || in_xfer)) close_win = 1'b1;
        if (close_win) begin
          state_d    = ST_SCAN;
          idx_d      = '0;
          best_cnt_d = '0;
          best_cls_d = '0;
        end
      end

      ST_SCAN: begin
        // Strict compare keeps the lowest class code on ties.
        if (bin_q[idx_q] > best_cnt_q) begin
          best_cnt_d = bin_q[idx_q];
          best_cls_d = idx_q;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          out_class_d = best_cls_d;
          out_count_d = best_cnt_d;
          out_total_d = total_q;
          state_d     = ST_EMIT;
        end
      end

      ST_EMIT: begin
        if (out_xfer) begin
          for (int i = 0; i < NBINS; i++) bin_d[i] = '0;
          total_d = '0;
          state_d = ST_ACCUM;
        end
      end

      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      for (int i = 0; i < NBINS; i++) bin_q[i] <= '0;
      total_q     <= '0;
      idx_q       <= '0;
      best_cnt_q  <= '0;
      best_cls_q  <= '0;
      out_class_q <= '0;
      out_count_q <= '0;
      out_total_q <= '0;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < NBINS; i++) bin_q[i] <= bin_d[i];
      total_q     <= total_d;
      idx_q       <= idx_d;
      best_cnt_q  <= best_cnt_d;
      best_cls_q  <= best_cls_d;
      out_class_q <= out_class_d;
      out_count_q <= out_count_d;
      out_total_q <= out_total_d;
    end
  end

endmodule
